// File: rtl/rv_pkg.sv
// Shared RISC-V front-end definitions: default datapath width, instruction size
// and the fetch-queue state encoding.
package rv_pkg;

    localparam int XLEN_DEFAULT = 32;
    localparam int INSTR_BYTES  = 4;

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_FAULT = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/rv_sync_fifo.sv
// Synchronous FIFO with flop storage; the head word is read straight from the
// storage flops, so data written on one edge is visible after that edge.
module rv_sync_fifo
    import rv_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = XLEN_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push_s, do_pop_s, full_s;

    assign empty     = (count_q == {CW{1'b0}});
    assign full_s    = (count_q == CW'(DEPTH));
    assign do_pop_s  = pop && !empty;
    assign do_push_s = push && (!full_s || do_pop_s);
    assign rdata     = mem_q[rd_ptr_q];
    assign count     = count_q;

    // Next-state for pointers, occupancy and storage; flush wins over push/pop.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = (do_push_s && !flush && (wr_ptr_q == PW'(i))) ? wdata : mem_q[i];
        end
        if (flush) begin
            wr_ptr_d = {PW{1'b0}};
            rd_ptr_d = {PW{1'b0}};
            count_d  = {CW{1'b0}};
        end else begin
            wr_ptr_d = do_push_s ? wr_ptr_q + PW'(1) : wr_ptr_q;
            rd_ptr_d = do_pop_s  ? rd_ptr_q + PW'(1) : rd_ptr_q;
            count_d  = count_q + CW'(do_push_s) - CW'(do_pop_s);
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {WIDTH{1'b0}};
            end
            wr_ptr_q <= {PW{1'b0}};
            rd_ptr_q <= {PW{1'b0}};
            count_q  <= {CW{1'b0}};
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/rv_fetch_queue.sv
// Instruction fetch queue: credit-limited request issue, in-order response
// buffering, redirect flush with stale-response discard. Optional misaligned
// redirect trapping is enabled by defining FETCH_ALIGN_CHECK_EN.
module rv_fetch_queue
    import rv_pkg::*;
#(
    parameter int              XLEN     = XLEN_DEFAULT,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = {XLEN{1'b0}}
) (
    input  logic            clk,
    input  logic            rst,
    output logic            req_valid,
    input  logic            req_ready,
    output logic [XLEN-1:0] req_addr,
    input  logic            rsp_valid,
    input  logic [XLEN-1:0] rsp_data,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] instr_data,
    output logic [XLEN-1:0] instr_pc,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            fetch_fault
);

    localparam int              PW         = $clog2(DEPTH);
    localparam int              CW         = PW + 1;
    localparam logic [XLEN-1:0] PC_STEP    = XLEN'(INSTR_BYTES);
    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(INSTR_BYTES - 1);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d, head_pc_q, head_pc_d;
    logic [CW-1:0]   outstanding_q, outstanding_d, drop_cnt_q, drop_cnt_d;
    logic [CW-1:0]   occupancy_s;
    logic [CW:0]     in_use_s;
    logic [XLEN-1:0] target_pc_s;
    logic            misaligned_s, req_fire_s, rsp_count_s, rsp_drop_s;
    logic            push_s, pop_s, fifo_empty_s;

`ifdef FETCH_ALIGN_CHECK_EN
    assign target_pc_s  = redirect_pc;
    assign misaligned_s = ((redirect_pc & ~ALIGN_MASK) != {XLEN{1'b0}});
    assign fetch_fault  = (state_q == ST_FAULT);
`else
    assign target_pc_s  = redirect_pc & ALIGN_MASK;
    assign misaligned_s = 1'b0;
    assign fetch_fault  = 1'b0;
`endif

    // Buffered entries plus requests in flight must never exceed the buffer size.
    assign in_use_s    = {1'b0, occupancy_s} + {1'b0, outstanding_q};
    assign req_valid   = rst && (state_q == ST_RUN) && !redirect_valid
                         && (in_use_s < (CW+1)'(DEPTH));
    assign req_addr    = fetch_pc_q;
    assign req_fire_s  = req_valid && req_ready;
    // A response with nothing outstanding belongs to a pre-reset request.
    assign rsp_count_s = rsp_valid && (outstanding_q != {CW{1'b0}});
    assign rsp_drop_s  = rsp_count_s && (drop_cnt_q != {CW{1'b0}});
    assign push_s      = rsp_count_s && !redirect_valid && (drop_cnt_q == {CW{1'b0}});
    assign pop_s       = instr_valid && instr_ready && !redirect_valid;
    assign instr_valid = !fifo_empty_s;
    assign instr_pc    = head_pc_q;

    rv_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (XLEN)
    ) u_buf (
        .clk   (clk),
        .rst   (rst),
        .flush (redirect_valid),
        .push  (push_s),
        .wdata (rsp_data),
        .pop   (pop_s),
        .rdata (instr_data),
        .count (occupancy_s),
        .empty (fifo_empty_s)
    );

    // Next-state for PCs, credit/drop counters and the fault FSM.
    always_comb begin
        outstanding_d = outstanding_q + CW'(req_fire_s) - CW'(rsp_count_s);
        state_d       = state_q;
        if (redirect_valid) begin
            fetch_pc_d = target_pc_s;
            head_pc_d  = target_pc_s;
            drop_cnt_d = outstanding_d;
        end else begin
            fetch_pc_d = req_fire_s ? fetch_pc_q + PC_STEP : fetch_pc_q;
            head_pc_d  = pop_s ? head_pc_q + PC_STEP : head_pc_q;
            drop_cnt_d = rsp_drop_s ? drop_cnt_q - CW'(1) : drop_cnt_q;
        end
        case (state_q)
            ST_RUN:   state_d = (redirect_valid && misaligned_s) ? ST_FAULT : ST_RUN;
            ST_FAULT: state_d = (redirect_valid && !misaligned_s) ? ST_RUN : ST_FAULT;
            default:  state_d = ST_RUN;
        endcase
    end

    // State registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_RUN;
            fetch_pc_q    <= RESET_PC;
            head_pc_q     <= RESET_PC;
            outstanding_q <= {CW{1'b0}};
            drop_cnt_q    <= {CW{1'b0}};
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            head_pc_q     <= head_pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
        end
    end

endmodule

// File: tb/tb_rv_fetch_queue.sv
// Self-checking bench for rv_fetch_queue: random memory latency, decode stalls
// and redirects checked against an epoch-based model of the fetch stream.
module tb_rv_fetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    typedef struct {
        logic [31:0] addr;
        int          epoch;
    } pend_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid, req_ready = 1'b0;
    logic [31:0] req_addr;
    logic        rsp_valid = 1'b0;
    logic [31:0] rsp_data = 32'h0;
    logic        instr_valid, instr_ready = 1'b0;
    logic [31:0] instr_data, instr_pc;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        fetch_fault;

    int          checks = 0;
    int          failures = 0;
    int          dut_acc = 0;
    int          epoch = 0;
    pend_t       pend[$];
    logic [31:0] m_buf[$];
    logic [31:0] m_fetch_pc, m_head_pc;
    logic        m_fault;
    logic        want_pop = 1'b0, want_req = 1'b0;
    logic [31:0] first_pop_pc = 32'hFFFF_FFFF, first_req_addr = 32'hFFFF_FFFF;

    rv_fetch_queue #(
        .XLEN     (32),
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_addr       (req_addr),
        .rsp_valid      (rsp_valid),
        .rsp_data       (rsp_data),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr_data     (instr_data),
        .instr_pc       (instr_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .fetch_fault    (fetch_fault)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memw(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hDEAD_BEEF;
    endfunction

    // One clock cycle: drive inputs at the negedge, check, then update the model.
    // rsp_mode: 0 = memory silent, 1 = respond whenever possible, 2 = random.
    task automatic cycle(input logic rdy, input logic ir, input logic rv,
                         input logic [31:0] rpc, input int rsp_mode);
        logic        exp_req, fire, mis;
        logic [31:0] tgt, addr_s;
        pend_t       e;
        req_ready = rdy; instr_ready = ir; redirect_valid = rv; redirect_pc = rpc;
        rsp_valid = 1'b0; rsp_data = 32'h0;
        if (pend.size() > 0 && (rsp_mode == 1 || (rsp_mode == 2 && $urandom_range(0, 99) < 60))) begin
            rsp_valid = 1'b1;
            rsp_data  = memw(pend[0].addr);
        end
        #1;
        exp_req = !m_fault && !rv && ((pend.size() + m_buf.size()) < DEPTH);
        checks++;
        if (req_valid !== exp_req) begin
            failures++; $display("FAIL req_valid got=%b exp=%b t=%0t", req_valid, exp_req, $time);
        end
        if (req_valid === 1'b1) begin
            checks++;
            if (req_addr !== m_fetch_pc) begin
                failures++; $display("FAIL req_addr got=%h exp=%h t=%0t", req_addr, m_fetch_pc, $time);
            end
        end
        checks++;
        if (instr_valid !== (m_buf.size() > 0)) begin
            failures++; $display("FAIL instr_valid got=%b exp_entries=%0d t=%0t", instr_valid, m_buf.size(), $time);
        end
        checks++;
        if (instr_pc !== m_head_pc) begin
            failures++; $display("FAIL instr_pc got=%h exp=%h t=%0t", instr_pc, m_head_pc, $time);
        end
        if (m_buf.size() > 0) begin
            checks++;
            if (instr_data !== memw(m_buf[0])) begin
                failures++; $display("FAIL instr_data got=%h exp=%h t=%0t", instr_data, memw(m_buf[0]), $time);
            end
        end
        checks++;
        if (fetch_fault !== m_fault) begin
            failures++; $display("FAIL fetch_fault got=%b exp=%b t=%0t", fetch_fault, m_fault, $time);
        end
        fire   = (req_valid === 1'b1) && rdy;
        addr_s = req_addr;
        if (fire) begin
            dut_acc++;
            if (want_req) begin first_req_addr = addr_s; want_req = 1'b0; end
        end
        if (want_pop && instr_valid === 1'b1 && ir && !rv) begin
            first_pop_pc = instr_pc; want_pop = 1'b0;
        end
        @(posedge clk);
        e = '{addr: 32'h0, epoch: -1};
        if (rsp_valid) e = pend.pop_front();
        if (fire) pend.push_back('{addr: addr_s, epoch: epoch});
        if (rv) begin
            epoch++;
            m_buf.delete();
`ifdef FETCH_ALIGN_CHECK_EN
            mis     = (rpc[1:0] != 2'b00);
            tgt     = rpc;
            m_fault = mis;
`else
            mis = 1'b0;
            tgt = {rpc[31:2], 2'b00};
`endif
            m_fetch_pc = tgt;
            m_head_pc  = tgt;
        end else begin
            if (ir && m_buf.size() > 0) begin
                void'(m_buf.pop_front());
                m_head_pc = m_head_pc + 32'd4;
            end
            if (rsp_valid && e.epoch == epoch) m_buf.push_back(e.addr);
            if (fire) m_fetch_pc = m_fetch_pc + 32'd4;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0; req_ready = 1'b0; instr_ready = 1'b0; redirect_valid = 1'b0;
        redirect_pc = 32'h0; rsp_valid = 1'b0;
        #1;
        checks++;
        if (req_valid !== 1'b0 || instr_valid !== 1'b0 || fetch_fault !== 1'b0) begin
            failures++; $display("FAIL reset_outputs req_valid=%b instr_valid=%b fetch_fault=%b exp=000",
                                 req_valid, instr_valid, fetch_fault);
        end
        checks++;
        if (instr_pc !== RESET_PC || req_addr !== RESET_PC) begin
            failures++; $display("FAIL reset_pcs instr_pc=%h req_addr=%h exp=%h", instr_pc, req_addr, RESET_PC);
        end
        @(negedge clk);
        pend.delete(); m_buf.delete();
        m_fetch_pc = RESET_PC; m_head_pc = RESET_PC; m_fault = 1'b0;
        dut_acc = 0;
        rst = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        want_req = 1'b1;
        cycle(1'b1, 1'b0, 1'b0, 32'h0, 0);
        checks++;
        if (first_req_addr !== RESET_PC) begin
            failures++; $display("FAIL first_request got=%h exp=%h", first_req_addr, RESET_PC);
        end
    endtask

    task automatic test_sequential();
        int pops = 0;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            if (instr_valid === 1'b1) pops++;
            cycle(1'b1, 1'b1, 1'b0, 32'h0, 1);
        end
        checks++;
        if (dut_acc != 16) begin
            failures++; $display("FAIL seq_requests got=%0d exp=16", dut_acc);
        end
        checks++;
        if (pops != 14) begin
            failures++; $display("FAIL seq_pops got=%0d exp=14", pops);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 1'b0, 32'h0, 1);
        checks++;
        if (dut_acc != DEPTH) begin
            failures++; $display("FAIL credit_limit got=%0d exp=%0d", dut_acc, DEPTH);
        end
        cycle(1'b1, 1'b1, 1'b0, 32'h0, 1);
        for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 1'b0, 32'h0, 1);
        checks++;
        if (dut_acc != DEPTH + 1) begin
            failures++; $display("FAIL credit_return got=%0d exp=%0d", dut_acc, DEPTH + 1);
        end
    endtask

    task automatic test_redirect();
        do_reset();
        cycle(1'b1, 1'b0, 1'b0, 32'h0, 0);
        cycle(1'b1, 1'b0, 1'b0, 32'h0, 0);
        want_pop = 1'b1;
        cycle(1'b1, 1'b1, 1'b1, 32'h0000_0100, 0);
        for (int i = 0; i < 10; i++) cycle(1'b1, 1'b1, 1'b0, 32'h0, 1);
        checks++;
        if (first_pop_pc !== 32'h0000_0100) begin
            failures++; $display("FAIL redirect_first_pc got=%h exp=00000100", first_pop_pc);
        end
    endtask

    task automatic test_redirect_collide();
        do_reset();
        cycle(1'b1, 1'b0, 1'b0, 32'h0, 1);
        cycle(1'b1, 1'b0, 1'b0, 32'h0, 1);
        cycle(1'b1, 1'b0, 1'b0, 32'h0, 1);
        cycle(1'b1, 1'b1, 1'b1, 32'h0000_0040, 1);
        #1;
        checks++;
        if (instr_valid !== 1'b0 || instr_pc !== 32'h0000_0040) begin
            failures++; $display("FAIL collide_flush instr_valid=%b instr_pc=%h exp=0/00000040", instr_valid, instr_pc);
        end
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b1, 1'b0, 32'h0, 1);
    endtask

    task automatic test_align();
        int acc0;
        do_reset();
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 1'b0, 32'h0, 1);
        want_req = 1'b1;
        first_req_addr = 32'hFFFF_FFFF;
        cycle(1'b1, 1'b1, 1'b1, 32'h0000_0102, 1);
`ifdef FETCH_ALIGN_CHECK_EN
        acc0 = dut_acc;
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, 1'b0, 32'h0, 1);
        #1;
        checks++;
        if (fetch_fault !== 1'b1 || dut_acc != acc0) begin
            failures++; $display("FAIL align_fault fetch_fault=%b new_requests=%0d exp=1/0", fetch_fault, dut_acc - acc0);
        end
        want_req = 1'b1;
        cycle(1'b1, 1'b1, 1'b1, 32'h0000_0200, 1);
        for (int i = 0; i < 6; i++) cycle(1'b1, 1'b1, 1'b0, 32'h0, 1);
        checks++;
        if (first_req_addr !== 32'h0000_0200 || fetch_fault !== 1'b0) begin
            failures++; $display("FAIL align_recover first_req=%h fault=%b exp=00000200/0", first_req_addr, fetch_fault);
        end
`else
        acc0 = dut_acc;
        for (int i = 0; i < 6; i++) cycle(1'b1, 1'b1, 1'b0, 32'h0, 1);
        checks++;
        if (first_req_addr !== 32'h0000_0100 || fetch_fault !== 1'b0 || dut_acc == acc0) begin
            failures++; $display("FAIL align_force first_req=%h fault=%b exp=00000100/0", first_req_addr, fetch_fault);
        end
`endif
    endtask

    task automatic test_random();
        logic [31:0] rpc;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            rpc = $urandom();
            rpc[31:16] = 16'h0;
            if ($urandom_range(0, 9) != 0) rpc[1:0] = 2'b00;
            if (i == 1500) do_reset();
            cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0),
                  1'($urandom_range(0, 99) < 3), rpc, 2);
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_backpressure();
        test_redirect();
        test_redirect_collide();
        test_align();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rv_fetch_queue.md
RV_FETCH_QUEUE -- requirements
Module: rv_fetch_queue

Interface
REQ-001 SHALL have parameter XLEN, default 32: address and instruction width.
REQ-002 SHALL have parameter DEPTH, default 4: instruction buffer entries; a power of two, at least 2.
REQ-003 SHALL have parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-004 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have ports req_valid output 1, req_ready input 1, req_addr output XLEN: the instruction memory request channel.
REQ-007 SHALL have ports rsp_valid input 1, rsp_data input XLEN: the memory response channel; in order, no backpressure.
REQ-008 SHALL have ports instr_valid output 1, instr_ready input 1, instr_data output XLEN, instr_pc output XLEN: the decode-side channel.
REQ-009 SHALL have ports redirect_valid input 1, redirect_pc input XLEN: branch, jump or JALR target.
REQ-010 SHALL have port fetch_fault, output, 1: sticky misaligned-redirect flag.

Function
REQ-011 SHALL count a request accepted when req_valid && req_ready; fetch_pc SHALL then advance by 4.
REQ-012 SHALL drive req_addr = fetch_pc.
REQ-013 SHALL assert req_valid only in RUN state, only with redirect_valid low, and only when occupancy + outstanding < DEPTH (credit rule; the buffer never overflows).
REQ-014 SHALL write a response not marked for discard into the buffer; it SHALL appear at instr_data one cycle after rsp_valid (registered, no bypass).
REQ-015 SHALL pop the head entry on instr_valid && instr_ready; instr_pc SHALL equal the head address and then advance by 4.
REQ-016 SHALL, on redirect_valid: empty the buffer, set fetch_pc and head pc to redirect_pc, and load drop_cnt with all outstanding requests (including any accepted that cycle).
REQ-017 SHALL drop responses while drop_cnt > 0 and decrement drop_cnt on each; a response in the same cycle as a redirect SHALL be dropped.
REQ-018 SHALL give redirect priority over a simultaneous pop and a simultaneous push.
REQ-019 SHALL support simultaneous push and pop on a full buffer: occupancy unchanged, order preserved.
REQ-020 SHALL use pointers of clog2(DEPTH) bits that wrap modulo DEPTH, and occupancy, outstanding and drop_cnt counters of clog2(DEPTH)+1 bits.
REQ-021 SHALL use FSM states RUN and FAULT: reset enters RUN; RUN goes to FAULT per REQ-026; FAULT returns to RUN only on an aligned redirect.
REQ-022 SHALL never assert req_valid in FAULT; outstanding responses SHALL still be drained and discarded in FAULT.

Reset
REQ-023 SHALL, while rst = 0: req_valid = 0, instr_valid = 0, fetch_fault = 0, buffer empty, all counters 0, fetch_pc = RESET_PC, head pc = RESET_PC, state RUN.
REQ-024 SHALL issue the first request at RESET_PC in the first cycle after rst deasserts.
REQ-025 SHALL, on reset mid-operation, lose all in-flight state; responses to pre-reset requests are the memory's responsibility and are not tracked.

Configuration
REQ-026 SHALL, with FETCH_ALIGN_CHECK_EN defined, treat redirect_pc[1:0] != 0 as misaligned: enter FAULT, set fetch_fault (held until an aligned redirect clears it), and flush as in REQ-016.
REQ-027 SHALL, without FETCH_ALIGN_CHECK_EN, force redirect_pc[1:0] to 0, tie fetch_fault to 0, and never enter FAULT.

Structure
REQ-028 SHALL place in shared package rv_pkg: XLEN default, the fetch state enum, and INSTR_BYTES = 4.
REQ-029 SHALL use one sub-module, rv_sync_fifo (DEPTH x XLEN, registered output), for the buffer; credit, drop and FSM logic SHALL stay in rv_fetch_queue.

Verification
REQ-030 SHALL cover reset release with req_ready = 1 and 1-cycle memory latency: req_addr sequence 0x0, 0x4, 0x8...; instr_pc matches; instr_data = memory word.
REQ-031 SHALL cover instr_ready = 0 with DEPTH = 4: exactly 4 requests issued, then req_valid low; one pop re-enables exactly one request.
REQ-032 SHALL cover redirect to 0x100 with 2 requests outstanding: those 2 responses are dropped, next instr_pc = 0x100, no stale instruction is seen.
REQ-033 SHALL cover redirect coinciding with rsp_valid and instr_ready: the response is dropped, no pop counted, buffer empty next cycle.
REQ-034 SHALL cover, with FETCH_ALIGN_CHECK_EN, redirect to 0x102: fetch_fault = 1 and req_valid stays low; a later redirect to 0x200 clears the fault and fetches from 0x200.
REQ-035 SHALL cover, without FETCH_ALIGN_CHECK_EN, redirect to 0x102: fetch resumes at 0x100 and fetch_fault stays 0.
